// File: rtl/change_dispenser.sv
// Output-actuator stage after vending_machine: runs the goods motor, then pays change
// one coin at a time through a hopper, confirming each coin with the exit sensor.
module change_dispenser #(
   parameter int unsigned VEND_CYCLES    = 8,
   parameter int unsigned PULSE_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] change,
   input  logic [2:0] sell,
   input  logic       hopper_sense,
   output logic [2:0] goods_drive,
   output logic       hopper_drive,
   output logic [3:0] coins_out,
   output logic       busy,
   output logic       done,
   output logic       sel_err,
   output logic       fault
);

   localparam int unsigned MAX_VP  = (VEND_CYCLES > PULSE_CYCLES) ? VEND_CYCLES : PULSE_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_VP > TIMEOUT_CYCLES) ? MAX_VP : TIMEOUT_CYCLES;
   localparam int unsigned TW      = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      VEND      = 3'd1,
      PAY_DRIVE = 3'd2,
      PAY_WAIT  = 3'd3,
      DONE      = 3'd4,
      FAULT     = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic            armed_q, armed_d;
   logic [3:0]      rem_q, rem_d;
   logic [2:0]      goods_q, goods_d;
   logic            err_q, err_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            sense_q;
   logic [3:0]      coins_d;
   logic [2:0]      goods_drive_d;
   logic            hopper_drive_d, busy_d, done_d, sel_err_d, fault_d;

   logic inputs_zero, sell_onehot, sense_edge, accept;

   always_comb begin
      inputs_zero = (change == 4'd0) && (sell == 3'd0);
      sell_onehot = (sell == 3'b001) || (sell == 3'b010) || (sell == 3'b100);
      sense_edge  = hopper_sense && !sense_q;
      accept      = sense_edge && (rem_q != 4'd0) &&
                    ((state_q == PAY_DRIVE) || (state_q == PAY_WAIT));
   end

   // Next-state, datapath and next-output logic
   always_comb begin
      state_d = state_q;
      armed_d = armed_q || inputs_zero;
      rem_d   = rem_q;
      goods_d = goods_q;
      err_d   = err_q;
      timer_d = timer_q + TW'(1);
      coins_d = coins_out;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (armed_q && !inputs_zero) begin
               armed_d = 1'b0;
               rem_d   = change;
               goods_d = sell_onehot ? sell : 3'd0;
               err_d   = !sell_onehot && (sell != 3'd0);
               coins_d = 4'd0;
               if (sell_onehot)          state_d = VEND;
               else if (change != 4'd0)  state_d = PAY_DRIVE;
               else                      state_d = DONE;
            end
         end
         VEND: begin
            if (timer_q == TW'(VEND_CYCLES - 1)) begin
               timer_d = '0;
               state_d = (rem_q != 4'd0) ? PAY_DRIVE : DONE;
            end
         end
         PAY_DRIVE, PAY_WAIT: begin
            // A confirmed coin outranks both pulse end and timeout
            if (accept) begin
               rem_d   = rem_q - 4'd1;
               coins_d = coins_out + 4'd1;
               timer_d = '0;
               state_d = (rem_q == 4'd1) ? DONE : PAY_DRIVE;
            end else if (state_q == PAY_DRIVE) begin
               if (timer_q == TW'(PULSE_CYCLES - 1)) begin
                  timer_d = '0;
                  state_d = PAY_WAIT;
               end
            end else if (timer_q == TW'(TIMEOUT_CYCLES)) begin
               timer_d = '0;
               state_d = FAULT;
            end
         end
         DONE: begin
            timer_d = '0;
            state_d = IDLE;
         end
         FAULT: begin
            timer_d = '0;
         end
         default: begin
            timer_d = '0;
            state_d = IDLE;
         end
      endcase

      goods_drive_d  = (state_d == VEND) ? goods_d : 3'd0;
      hopper_drive_d = (state_d == PAY_DRIVE);
      busy_d         = (state_d != IDLE);
      done_d         = (state_d == DONE);
      sel_err_d      = (state_d == DONE) && err_d;
      fault_d        = (state_d == FAULT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         armed_q      <= 1'b0;
         rem_q        <= 4'd0;
         goods_q      <= 3'd0;
         err_q        <= 1'b0;
         timer_q      <= '0;
         sense_q      <= 1'b0;
         coins_out    <= 4'd0;
         goods_drive  <= 3'd0;
         hopper_drive <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sel_err      <= 1'b0;
         fault        <= 1'b0;
      end else begin
         state_q      <= state_d;
         armed_q      <= armed_d;
         rem_q        <= rem_d;
         goods_q      <= goods_d;
         err_q        <= err_d;
         timer_q      <= timer_d;
         sense_q      <= hopper_sense;
         coins_out    <= coins_d;
         goods_drive  <= goods_drive_d;
         hopper_drive <= hopper_drive_d;
         busy         <= busy_d;
         done         <= done_d;
         sel_err      <= sel_err_d;
         fault        <= fault_d;
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: builds an expected per-cycle timeline for each transaction
// from the dispenser's timing rules and compares every output every cycle.
module tb_change_dispenser;

   localparam int V  = 8;
   localparam int P  = 4;
   localparam int TO = 64;
   localparam int N  = 1200;

   logic       clk, rst;
   logic [3:0] change;
   logic [2:0] sell;
   logic       hopper_sense;
   logic [2:0] goods_drive;
   logic       hopper_drive;
   logic [3:0] coins_out;
   logic       busy, done, sel_err, fault;

   int total = 0;
   int bad   = 0;

   // expected timeline, indexed by clock edge after capture (edge 0 = capture)
   logic [2:0] xgd [N];
   bit         xhd [N];
   bit         xdone [N];
   bit         xerr [N];
   bit         xbusy [N];
   bit         xfault [N];
   int         xcoins [N];
   bit         coin_at [N];
   bit         senseat [N];
   int         dly [16];
   int         model_coins = 0;

   change_dispenser #(.VEND_CYCLES(V), .PULSE_CYCLES(P), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .change(change), .sell(sell), .hopper_sense(hopper_sense),
      .goods_drive(goods_drive), .hopper_drive(hopper_drive), .coins_out(coins_out),
      .busy(busy), .done(done), .sel_err(sel_err), .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] out_vec();
      return {goods_drive, hopper_drive, coins_out, busy, done, sel_err, fault};
   endfunction

   // One transaction: the bench acts as the hopper, dropping the n-th coin dly[n] edges
   // after its drive pulse starts; coin 'stall' never drops. s1/s2 are stray sensor edges.
   task automatic run_txn(input logic [3:0] chg, input logic [2:0] sel, input int hold,
                          input int stall, input int s1, input int s2, input string name);
      int t, s, S, last, c;
      bit valid, err, faulted;
      logic [2:0] g;
      logic [11:0] exp_v;
      for (int e = 0; e < N; e++) begin
         xgd[e] = 3'd0; xhd[e] = 0; xdone[e] = 0; xerr[e] = 0; xbusy[e] = 0;
         xfault[e] = 0; xcoins[e] = 0; coin_at[e] = 0; senseat[e] = 0;
      end
      valid = (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
      g     = valid ? sel : 3'd0;
      err   = !valid && (sel != 3'd0);
      t = 0;
      if (valid) begin
         for (int e = 0; e < V; e++) xgd[e] = g;
         t = V;
      end
      faulted = 0;
      for (int i = 0; i < int'(chg); i++) begin
         s = t;
         if (i == stall) begin
            for (int e = s; e < s + P; e++) xhd[e] = 1;
            t = s + P + TO + 1;
            faulted = 1;
            break;
         end
         S = s + dly[i];
         for (int e = s; e < s + P && e < S; e++) xhd[e] = 1;
         senseat[S] = 1;
         coin_at[S] = 1;
         t = S;
      end
      if (faulted) begin
         last = t + 2;
         for (int e = t; e <= last; e++) xfault[e] = 1;
         for (int e = 0; e <= last; e++) xbusy[e] = 1;
      end else begin
         xdone[t] = 1;
         xerr[t]  = err;
         for (int e = 0; e <= t; e++) xbusy[e] = 1;
         last = (t + 1 > hold + 1) ? t + 1 : hold + 1;
      end
      if (s1 >= 0) senseat[s1] = 1;
      if (s2 >= 0) senseat[s2] = 1;
      c = 0;
      for (int e = 0; e <= last; e++) begin
         c += int'(coin_at[e]);
         xcoins[e] = c;
      end
      model_coins = c;

      change = 4'd0; sell = 3'd0; hopper_sense = 1'b0;
      @(posedge clk);
      #1;
      change = chg; sell = sel;
      @(posedge clk);
      for (int e = 0; e <= last; e++) begin
         #1;
         exp_v = {xgd[e], xhd[e], 4'(xcoins[e]), xbusy[e], xdone[e], xerr[e], xfault[e]};
         total++;
         if (out_vec() !== exp_v) begin
            bad++;
            $display("FAIL %s edge=%0d got gd/hd/coins/busy/done/err/fault=%b exp=%b",
                     name, e, out_vec(), exp_v);
         end
         change       = (e + 1 < hold) ? chg : 4'd0;
         sell         = (e + 1 < hold) ? sel : 3'd0;
         hopper_sense = senseat[e + 1];
         @(posedge clk);
      end
      #1;
      hopper_sense = 1'b0;
   endtask

   task automatic apply_reset(input string name);
      rst = 1'b1;
      #2;
      total++;
      if (out_vec() !== 12'd0) begin
         bad++;
         $display("FAIL %s got=%b exp=%b", name, out_vec(), 12'd0);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset("reset_state");
   endtask

   task automatic test_goods_change();
      for (int i = 0; i < 16; i++) dly[i] = P + 2;
      run_txn(4'd3, 3'b010, 4, -1, -1, -1, "goods_change");
   endtask

   task automatic test_refund();
      for (int i = 0; i < 16; i++) dly[i] = 3;
      run_txn(4'd2, 3'b000, 1, -1, -1, -1, "refund_only");
   endtask

   task automatic test_held();
      for (int i = 0; i < 16; i++) dly[i] = 5;
      run_txn(4'd1, 3'b001, 40, -1, -1, -1, "held_first");
      run_txn(4'd1, 3'b001, 40, -1, -1, -1, "held_reapply");
   endtask

   task automatic test_invalid();
      for (int i = 0; i < 16; i++) dly[i] = 3;
      run_txn(4'd1, 3'b110, 1, -1, -1, -1, "invalid_sel");
      run_txn(4'd0, 3'b101, 1, -1, -1, -1, "error_only");
   endtask

   task automatic test_timeout_boundary();
      dly[0] = P + TO + 1;
      run_txn(4'd1, 3'b000, 1, -1, -1, -1, "last_chance_coin");
   endtask

   task automatic test_early_stray();
      for (int i = 0; i < 16; i++) dly[i] = 2;
      run_txn(4'd2, 3'b100, 1, -1, 2, 5, "early_and_vend_stray");
      @(negedge clk); hopper_sense = 1'b1;
      @(negedge clk); hopper_sense = 1'b0;
      @(negedge clk);
      total++;
      if (coins_out !== 4'(model_coins) || busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_stray got coins=%0d busy=%b exp coins=%0d busy=0",
                  coins_out, busy, model_coins);
      end
   endtask

   task automatic test_stall();
      dly[0] = P + 2;
      run_txn(4'd2, 3'b000, 1, 1, -1, -1, "hopper_stall");
      apply_reset("reset_after_fault");
   endtask

   task automatic test_reset_vend();
      change = 4'd0; sell = 3'd0;
      @(posedge clk);
      #1 change = 4'd1; sell = 3'b001;
      @(posedge clk);
      #1 change = 4'd0; sell = 3'd0;
      total++;
      if (goods_drive !== 3'b001 || busy !== 1'b1) begin
         bad++;
         $display("FAIL vend_started got gd=%b busy=%b exp gd=001 busy=1", goods_drive, busy);
      end
      repeat (3) @(posedge clk);
      #2;
      apply_reset("reset_in_vend");
      for (int i = 0; i < 16; i++) dly[i] = 4;
      run_txn(4'd1, 3'b001, 1, -1, -1, -1, "after_vend_reset");
   endtask

   task automatic test_random();
      logic [3:0] chg;
      logic [2:0] sel;
      for (int k = 0; k < 20; k++) begin
         chg = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
         sel = 3'($urandom_range(0, 7));
         if (chg == 4'd0 && sel == 3'd0) chg = 4'd1;
         for (int i = 0; i < 16; i++)
            dly[i] = (chg == 4'd15) ? int'($urandom_range(2, P + 3))
                                    : int'($urandom_range(2, P + TO + 1));
         run_txn(chg, sel, int'($urandom_range(1, 12)), -1, -1, -1, "random");
      end
   endtask

   initial begin
      rst = 1'b1; change = 4'd0; sell = 3'd0; hopper_sense = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      test_goods_change();
      test_refund();
      test_held();
      test_invalid();
      test_timeout_boundary();
      test_early_stray();
      test_stall();
      test_reset_vend();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
